ledger_tx_source: RTL and testbench

//  Initiator end of the ledger transaction interface: generates pseudo-random transfer requests
//  (payer, payee, amount) for the ledger pipeline and consumes its result stream.

---
 rtl/ledger_pkg.sv | 25 ++
 rtl/ledger_tx_scoreboard.sv | 63 ++++++
 rtl/ledger_tx_source.sv | 185 ++++++++++++++++++
 tb/tb_ledger_tx_source.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ledger_pkg.sv
// Shared types, constants and helpers for the ledger transaction source.
package ledger_pkg;

    localparam int USER_W_DEFAULT    = 10;
    localparam int BALANCE_W_DEFAULT = 64;

    // Types at the default interface widths.
    typedef logic [USER_W_DEFAULT-1:0]    user_t;
    typedef logic [BALANCE_W_DEFAULT-1:0] amount_t;

    localparam int          LEDGER_LATENCY = 2;
    localparam logic [31:0] LFSR_POLY      = 32'h8020_0003;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} tx_state_e;

    // One step of the right-shifting Galois LFSR.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'd0);
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] c);
        return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
    endfunction

endpackage

// File: rtl/ledger_tx_scoreboard.sv
// Small synchronous FIFO of issued {payer,payee} pairs; each pop is compared
// against the returned result and a mismatch (or pop from empty) is flagged.
module ledger_tx_scoreboard #(
    parameter int ENTRY_W = 20,
    parameter int DEPTH   = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_data,
    input  logic               pop,
    input  logic [ENTRY_W-1:0] pop_data,
    output logic               empty,
    output logic               full,
    output logic               mismatch
);
    import ledger_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]     count_q, count_d;
    logic               do_push, do_pop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == (PTR_W+1)'(DEPTH));
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    // A pop against an empty FIFO is itself an error; the pop is dropped.
    assign mismatch = pop && (empty || (mem_q[rd_ptr_q] != pop_data));

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/ledger_tx_source.sv
// Ledger transaction initiator: LFSR request generator, hazard spacing, result scoreboard and stats.
// Optional macro LEDGER_TX_SELF_XFER_EN: issue payer==payee candidates unchanged as no-op transfers.
module ledger_tx_source #(
    parameter int          USER_WIDTH    = 10,
    parameter int          BALANCE_WIDTH = 64,
    parameter int          AMOUNT_BITS   = 8,
    parameter logic [31:0] LFSR_SEED     = 32'hACE1_2345,
    parameter int          SB_DEPTH      = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic                     stop,
    input  logic [31:0]              tx_target,
    output logic                     tx_valid,
    output logic [USER_WIDTH-1:0]    tx_payer,
    output logic [USER_WIDTH-1:0]    tx_payee,
    output logic [BALANCE_WIDTH-1:0] tx_amount,
    input  logic                     rs_valid,
    input  logic                     rs_success,
    input  logic [USER_WIDTH-1:0]    rs_payer,
    input  logic [USER_WIDTH-1:0]    rs_payee,
    output logic                     busy,
    output logic                     done,
    output logic [31:0]              issued_cnt,
    output logic [31:0]              success_cnt,
    output logic [31:0]              fail_cnt,
    output logic [31:0]              stall_cnt,
    output logic                     err_mismatch
);
    import ledger_pkg::*;

    localparam int UW = USER_WIDTH;
    localparam int AB = AMOUNT_BITS;

    generate
        if (LFSR_SEED == 32'd0) begin : g_bad_seed
            $error("ledger_tx_source: LFSR_SEED must be non-zero");
        end
        if (2*UW + AB > 32) begin : g_bad_width
            $error("ledger_tx_source: 2*USER_WIDTH+AMOUNT_BITS exceeds 32");
        end
        if (SB_DEPTH < LEDGER_LATENCY + 2 || (SB_DEPTH & (SB_DEPTH - 1)) != 0) begin : g_bad_depth
            $error("ledger_tx_source: SB_DEPTH must be a power of 2 and >= 4");
        end
    endgenerate

    tx_state_e              state_q, state_d;
    logic [31:0]            lfsr_q, lfsr_d;
    logic                   tx_valid_q, tx_valid_d;
    logic [UW-1:0]          tx_payer_q, tx_payer_d, tx_payee_q, tx_payee_d;
    logic [BALANCE_WIDTH-1:0] tx_amount_q, tx_amount_d;
    logic [31:0]            issued_q, issued_d, success_q, success_d;
    logic [31:0]            fail_q, fail_d, stall_q, stall_d;
    logic                   err_q, err_d;

    logic [UW-1:0]          cand_payer, cand_payee_raw, cand_payee;
    logic [BALANCE_WIDTH-1:0] cand_amount;
    logic                   hazard, issue, sb_empty, sb_full, sb_mismatch;

    assign cand_payer     = lfsr_q[UW-1:0];
    assign cand_payee_raw = lfsr_q[2*UW-1:UW];
    assign cand_amount    = BALANCE_WIDTH'(lfsr_q[2*UW+AB-1:2*UW]);

`ifdef LEDGER_TX_SELF_XFER_EN
    assign cand_payee = cand_payee_raw;
`else
    assign cand_payee = (cand_payee_raw == cand_payer) ? cand_payer + UW'(1) : cand_payee_raw;
`endif

    // Only the issue from the immediately preceding cycle can collide, so a
    // stalled cycle always clears the guard for the next one.
    assign hazard = tx_valid_q && ((cand_payer == tx_payer_q) || (cand_payer == tx_payee_q) ||
                                   (cand_payee == tx_payer_q) || (cand_payee == tx_payee_q));

    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        tx_valid_d  = 1'b0;
        tx_payer_d  = tx_payer_q;
        tx_payee_d  = tx_payee_q;
        tx_amount_d = tx_amount_q;
        issued_d    = issued_q;
        success_d   = success_q;
        fail_d      = fail_q;
        stall_d     = stall_q;
        err_d       = err_q;
        issue       = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    issued_d  = '0;
                    success_d = '0;
                    fail_d    = '0;
                    stall_d   = '0;
                    err_d     = 1'b0;
                    state_d   = (tx_target == 32'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = DRAIN;
                end else if (hazard || sb_full) begin
                    stall_d = sat_inc(stall_q);
                end else begin
                    issue       = 1'b1;
                    tx_valid_d  = 1'b1;
                    tx_payer_d  = cand_payer;
                    tx_payee_d  = cand_payee;
                    tx_amount_d = cand_amount;
                    lfsr_d      = lfsr_step(lfsr_q);
                    issued_d    = sat_inc(issued_q);
                    if (({1'b0, issued_q} + 33'd1) >= {1'b0, tx_target}) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (sb_empty) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        if (rs_valid && (state_q == RUN || state_q == DRAIN)) begin
            if (rs_success) success_d = sat_inc(success_q);
            else            fail_d    = sat_inc(fail_q);
        end
        if (sb_mismatch) err_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            lfsr_q      <= LFSR_SEED;
            tx_valid_q  <= 1'b0;
            tx_payer_q  <= '0;
            tx_payee_q  <= '0;
            tx_amount_q <= '0;
            issued_q    <= '0;
            success_q   <= '0;
            fail_q      <= '0;
            stall_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            tx_valid_q  <= tx_valid_d;
            tx_payer_q  <= tx_payer_d;
            tx_payee_q  <= tx_payee_d;
            tx_amount_q <= tx_amount_d;
            issued_q    <= issued_d;
            success_q   <= success_d;
            fail_q      <= fail_d;
            stall_q     <= stall_d;
            err_q       <= err_d;
        end
    end

    ledger_tx_scoreboard #(
        .ENTRY_W (2*UW),
        .DEPTH   (SB_DEPTH)
    ) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (issue),
        .push_data ({cand_payer, cand_payee}),
        .pop       (rs_valid),
        .pop_data  ({rs_payer, rs_payee}),
        .empty     (sb_empty),
        .full      (sb_full),
        .mismatch  (sb_mismatch)
    );

    assign tx_valid     = tx_valid_q;
    assign tx_payer     = tx_payer_q;
    assign tx_payee     = tx_payee_q;
    assign tx_amount    = tx_amount_q;
    assign busy         = (state_q == RUN) || (state_q == DRAIN);
    assign done         = (state_q == DONE);
    assign issued_cnt   = issued_q;
    assign success_cnt  = success_q;
    assign fail_cnt     = fail_q;
    assign stall_cnt    = stall_q;
    assign err_mismatch = err_q;

endmodule

// File: tb/tb_ledger_tx_source.sv
// Bench for ledger_tx_source: run table with a 2-cycle ledger model, a USER_WIDTH=1 spacing
// sequence and a mid-run reset sequence.
`timescale 1ns/1ps
module tb_ledger_tx_source;

    localparam logic [31:0] SEED = 32'hACE1_2345;
    localparam logic [31:0] POLY = 32'h8020_0003;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // default-parameter instance
    logic        start = 1'b0, stop = 1'b0;
    logic [31:0] tx_target = '0;
    logic        tx_valid;
    logic [9:0]  tx_payer, tx_payee;
    logic [63:0] tx_amount;
    logic        rs_valid = 1'b0, rs_success = 1'b0;
    logic [9:0]  rs_payer = '0, rs_payee = '0;
    logic        busy, done, err_mismatch;
    logic [31:0] issued_cnt, success_cnt, fail_cnt, stall_cnt;

    // USER_WIDTH=1 instance
    logic        u1_start = 1'b0, u1_stop = 1'b0;
    logic [31:0] u1_target = '0;
    logic        u1_tx_valid;
    logic [0:0]  u1_tx_payer, u1_tx_payee;
    logic [63:0] u1_tx_amount;
    logic        u1_rs_valid = 1'b0, u1_rs_success = 1'b1;
    logic [0:0]  u1_rs_payer = '0, u1_rs_payee = '0;
    logic        u1_busy, u1_done, u1_err;
    logic [31:0] u1_issued, u1_success, u1_fail, u1_stall;

    ledger_tx_source dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .tx_target(tx_target),
        .tx_valid(tx_valid), .tx_payer(tx_payer), .tx_payee(tx_payee), .tx_amount(tx_amount),
        .rs_valid(rs_valid), .rs_success(rs_success), .rs_payer(rs_payer), .rs_payee(rs_payee),
        .busy(busy), .done(done), .issued_cnt(issued_cnt), .success_cnt(success_cnt),
        .fail_cnt(fail_cnt), .stall_cnt(stall_cnt), .err_mismatch(err_mismatch)
    );

    ledger_tx_source #(.USER_WIDTH(1)) dut_u1 (
        .clk(clk), .rst_n(rst_n), .start(u1_start), .stop(u1_stop), .tx_target(u1_target),
        .tx_valid(u1_tx_valid), .tx_payer(u1_tx_payer), .tx_payee(u1_tx_payee),
        .tx_amount(u1_tx_amount), .rs_valid(u1_rs_valid), .rs_success(u1_rs_success),
        .rs_payer(u1_rs_payer), .rs_payee(u1_rs_payee), .busy(u1_busy), .done(u1_done),
        .issued_cnt(u1_issued), .success_cnt(u1_success), .fail_cnt(u1_fail),
        .stall_cnt(u1_stall), .err_mismatch(u1_err)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model state (driven from the specification's rules, not the RTL structure)
    logic [31:0] m_lfsr = SEED;
    int          cyc = 0, run_issues = 0, first_cyc = -1, last_cyc = -1, after_stop = 0;
    int          res_idx = 0, exp_succ = 0, exp_fail = 0, stop_after = 0, corrupt_at = 0;
    logic        prev_v = 1'b0, err_chk_next = 1'b0;
    logic [9:0]  prev_p = '0, prev_e = '0;
    logic [20:0] s1 = '0, s2 = '0;
    logic [2:0]  u1_s1 = '0, u1_s2 = '0;

    always @(negedge clk) begin
        logic [9:0]  ep, ee;
        logic [63:0] ea;
        logic        stop_was;
        if (err_chk_next) begin
            check("err_after_corrupt", err_mismatch, 1);
            err_chk_next = 1'b0;
        end
        if (!rst_n) begin
            m_lfsr = SEED;
            prev_v = 1'b0;
        end else begin
            cyc++;
            stop_was = stop;
            if (tx_valid) begin
                ep = 10'(m_lfsr % 1024);
                ee = 10'((m_lfsr >> 10) % 1024);
                ea = 64'((m_lfsr >> 20) % 256);
`ifdef LEDGER_TX_SELF_XFER_EN
`else
                if (ee == ep) ee = 10'((int'(ep) + 1) % 1024);
`endif
                check("tx_payer", tx_payer, ep);
                check("tx_payee", tx_payee, ee);
                check("tx_amount", tx_amount, ea);
                if (prev_v)
                    check("no_overlap", (tx_payer == prev_p) || (tx_payer == prev_e) ||
                                        (tx_payee == prev_p) || (tx_payee == prev_e), 0);
                if (stop_was) after_stop++;
                m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? POLY : 32'd0);
                run_issues++;
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
                if (stop_after > 0 && run_issues == stop_after) stop = 1'b1;
            end
            prev_v = tx_valid;
            prev_p = tx_payer;
            prev_e = tx_payee;
        end
        // ideal ledger: result two cycles after the issue is visible
        rs_valid   = s2[20];
        rs_payer   = s2[19:10];
        rs_payee   = s2[9:0];
        rs_success = 1'b0;
        if (s2[20]) begin
            res_idx++;
            rs_success = ($urandom_range(0, 3) != 0);
            if (rs_success) exp_succ++;
            else            exp_fail++;
            if (res_idx == corrupt_at) begin
                rs_payee     = rs_payee ^ 10'h001;
                err_chk_next = 1'b1;
            end
        end
        s2 = s1;
        s1 = {tx_valid, tx_payer, tx_payee};
    end

    always @(negedge clk) begin
        u1_rs_valid = u1_s2[2];
        u1_rs_payer = u1_s2[1];
        u1_rs_payee = u1_s2[0];
        u1_s2 = u1_s1;
        u1_s1 = {u1_tx_valid, u1_tx_payer, u1_tx_payee};
    end

    typedef struct {
        int   target;
        int   stop_after;
        int   corrupt;
        int   exp_issued;
        logic exp_err;
    } vec_t;

    task automatic run_case(input vec_t v, input int idx);
        int bound;
        logic got;
        @(negedge clk);
        stop = 1'b0; stop_after = v.stop_after; corrupt_at = v.corrupt; tx_target = v.target;
        run_issues = 0; first_cyc = -1; last_cyc = -1; after_stop = 0;
        res_idx = 0; exp_succ = 0; exp_fail = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check($sformatf("c%0d_clr_issued", idx), issued_cnt, 0);
        check($sformatf("c%0d_clr_err", idx), err_mismatch, 0);
        bound = ((v.target > 1000) ? 1000 : v.target) * 3 + 50;
        got = 1'b0;
        for (int c = 0; c < bound && !got; c++) begin
            @(negedge clk);
            got = done;
        end
        check($sformatf("c%0d_done", idx), got, 1);
        check($sformatf("c%0d_busy", idx), busy, 0);
        check($sformatf("c%0d_issued_cnt", idx), issued_cnt, v.exp_issued);
        check($sformatf("c%0d_issues_seen", idx), run_issues, v.exp_issued);
        check($sformatf("c%0d_results_seen", idx), exp_succ + exp_fail, v.exp_issued);
        check($sformatf("c%0d_success", idx), success_cnt, exp_succ);
        check($sformatf("c%0d_fail", idx), fail_cnt, exp_fail);
        check($sformatf("c%0d_stall", idx), stall_cnt,
              (run_issues > 0) ? (last_cyc - first_cyc + 1 - run_issues) : 0);
        check($sformatf("c%0d_err", idx), err_mismatch, v.exp_err);
        check($sformatf("c%0d_after_stop", idx), after_stop, 0);
    endtask

    initial begin
        vec_t       tbl[6];
        logic       got;
        logic       u1_exp_payee;
        logic [6:0] pat;

        tbl[0] = '{target: 0,    stop_after: 0,  corrupt: 0, exp_issued: 0,   exp_err: 1'b0};
        tbl[1] = '{target: 100,  stop_after: 0,  corrupt: 0, exp_issued: 100, exp_err: 1'b0};
        tbl[2] = '{target: 20,   stop_after: 0,  corrupt: 7, exp_issued: 20,  exp_err: 1'b1};
        tbl[3] = '{target: 5,    stop_after: 0,  corrupt: 0, exp_issued: 5,   exp_err: 1'b0};
        tbl[4] = '{target: 1000, stop_after: 10, corrupt: 0, exp_issued: 10,  exp_err: 1'b0};
        tbl[5].target     = $urandom_range(2, 40);
        tbl[5].stop_after = 0;
        tbl[5].corrupt    = 0;
        tbl[5].exp_issued = tbl[5].target;
        tbl[5].exp_err    = 1'b0;

        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_tx_payer", tx_payer, 0);
        check("rst_tx_amount", tx_amount, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_issued", issued_cnt, 0);
        check("rst_success", success_cnt, 0);
        check("rst_fail", fail_cnt, 0);
        check("rst_stall", stall_cnt, 0);
        check("rst_err", err_mismatch, 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) run_case(tbl[i], i);

        // USER_WIDTH=1: every candidate overlaps the previous issue
        @(negedge clk);
        u1_target = 4;
        u1_start  = 1'b1;
        @(negedge clk);
        u1_start = 1'b0;
        pat = 7'b1010101;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            check($sformatf("u1_valid_%0d", k), u1_tx_valid, pat[6-k]);
            if (u1_tx_valid) begin
                u1_exp_payee = ~u1_tx_payer;
                check("u1_payee_inv", u1_tx_payee, u1_exp_payee);
                check("u1_amount_range", u1_tx_amount < 64'd256, 1);
            end
        end
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            got = u1_done;
        end
        check("u1_done", got, 1);
        check("u1_busy", u1_busy, 0);
        check("u1_issued", u1_issued, 4);
        check("u1_stall", u1_stall, 3);
        check("u1_success", u1_success, 4);
        check("u1_fail", u1_fail, 0);
        check("u1_err", u1_err, 0);

        // asynchronous reset with results still in flight
        @(negedge clk);
        stop = 1'b0; stop_after = 0; corrupt_at = 0; tx_target = 1000;
        run_issues = 0; first_cyc = -1; last_cyc = -1; res_idx = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk);
            got = (run_issues >= 6);
        end
        check("rst_mid_prep", got, 1);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_tx_valid", tx_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_issued", issued_cnt, 0);
        check("mid_rst_stall", stall_cnt, 0);
        check("mid_rst_payer", tx_payer, 0);
        check("mid_rst_err", err_mismatch, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 6 && !got; c++) begin
            @(negedge clk);
            got = err_mismatch;
        end
        check("err_after_reset", got, 1);
        check("idle_after_reset", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
